control_sequencer: RTL and testbench

- Hardwired control unit for the CPU datapath. It generates every datapath strobe that benches currently drive by hand.
- Runs fetch (T0–T2), then decodes IR[31:27] and steps through the per-instruction micro-sequence (T3–T7). After the last step it returns to T0.
- Sits beside the datapath. Takes IR and CON from it and drives Gra/Grb/Grc, Rin/Rout, bus-source selects and register-load enables.

---
 rtl/control_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: runs the three fetch steps, decodes the opcode in
// IR[31:27] and walks the per-instruction micro-sequence. Afterwards it
// returns to T0, or parks in HALT.
module control_sequencer #(
    parameter int                  ALU_OP_W = 4,
    parameter logic [ALU_OP_W-1:0] OP_ADD   = 4'd0,
    parameter logic [ALU_OP_W-1:0] OP_SUB   = 4'd1,
    parameter logic [ALU_OP_W-1:0] OP_AND   = 4'd2,
    parameter logic [ALU_OP_W-1:0] OP_OR    = 4'd3
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                CON,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                memRead,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                R15in,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Cout,
    output logic                PCin,
    output logic                CONin,
    output logic                ramEnable,
    output logic                InPort_Out,
    output logic                OutPort_In,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run
);

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10100;
    localparam logic [4:0] OPC_JAL  = 5'b10101;
    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] opcode;
    logic       unused_ir;

    // IR is read live in every step; it is not reloaded between T3 and T0,
    // so no private copy of the opcode is kept.
    assign opcode    = IR[31:27];
    // Operand fields belong to the datapath; only the opcode matters here.
    assign unused_ir = ^IR[26:0];

    // State register with synchronous clear back to T0.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (clear) state <= T0;
        else       state <= next_state;
    end

    // Next-state decode and Moore strobes (br T6 also looks at CON).
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        memRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        R15in      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Cout       = 1'b0;
        PCin       = 1'b0;
        CONin      = 1'b0;
        ramEnable  = 1'b0;
        InPort_Out = 1'b0;
        OutPort_In = 1'b0;
        alu_op     = OP_ADD;
        run        = 1'b1;

        // While clear is asserted every strobe stays quiet and run reads 1.
        if (!clear) begin
            case (state)
                T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                    next_state = T1;
                end
                T1: begin
                    memRead = 1'b1; MDRin = 1'b1;
                    next_state = T2;
                end
                T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                    next_state = T3;
                end
                T3: begin
                    next_state = T0;
                    case (opcode)
                        OPC_LD, OPC_LDI, OPC_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; next_state = T4;
                        end
                        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
                            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; next_state = T4;
                        end
                        OPC_BR: begin
                            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; next_state = T4;
                        end
                        OPC_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OPC_JAL:  begin R15in = 1'b1; PCout = 1'b1; next_state = T4; end
                        OPC_IN:   begin Gra = 1'b1; Rin = 1'b1; InPort_Out = 1'b1; end
                        OPC_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_In = 1'b1; end
                        OPC_HALT: next_state = HALT;
                        default:  ;  // nop and undefined opcodes: one idle step
                    endcase
                end
                T4: begin
                    next_state = T5;
                    case (opcode)
                        OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI: begin
                            Cout = 1'b1; Zin = 1'b1;
                        end
                        OPC_ADD: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                        OPC_SUB: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OP_SUB; end
                        OPC_AND: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OP_AND; end
                        OPC_OR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = OP_OR;  end
                        OPC_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                        OPC_JAL: begin
                            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; next_state = T0;
                        end
                        default: next_state = T0;
                    endcase
                end
                T5: begin
                    next_state = T0;
                    case (opcode)
                        OPC_LD, OPC_ST: begin
                            Zlowout = 1'b1; MARin = 1'b1; next_state = T6;
                        end
                        OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        OPC_BR: begin Cout = 1'b1; Zin = 1'b1; next_state = T6; end
                        default: ;
                    endcase
                end
                T6: begin
                    next_state = T0;
                    case (opcode)
                        OPC_LD: begin memRead = 1'b1; MDRin = 1'b1; next_state = T7; end
                        OPC_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; next_state = T7;
                        end
                        // The step is always spent; only the PC update is conditional.
                        OPC_BR: begin Zlowout = CON; PCin = CON; end
                        default: ;
                    endcase
                end
                T7: begin
                    next_state = T0;
                    case (opcode)
                        OPC_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OPC_ST:  ramEnable = 1'b1;
                        default: ;
                    endcase
                end
                HALT: begin
                    run = 1'b0;
                    next_state = HALT;
                end
                default: next_state = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instruction streams, compared against a table-driven micro-program model.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR    = '0;
    logic        CON   = 1'b0;
    logic PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, R15in;
    logic Yin, Zin, Zlowout, Cout, PCin, CONin;
    logic ramEnable, InPort_Out, OutPort_In, run;
    logic [3:0] alu_op;

    int n_cmp = 0;
    int n_err = 0;

    // Bit positions of each strobe in the packed observation vector.
    localparam int PCOUT = 0,  MARIN = 1,  INCPC = 2,  MEMREAD = 3, MDRIN = 4;
    localparam int MDROUT = 5, IRIN = 6,   GRA = 7,    GRB = 8,     GRC = 9;
    localparam int RIN = 10,   ROUT = 11,  BAOUT = 12, R15IN = 13,  YIN = 14;
    localparam int ZIN = 15,   ZLOW = 16,  COUT = 17,  PCIN = 18,   CONIN = 19;
    localparam int RAMEN = 20, INOUT = 21, OUTIN = 22;

    localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2, ADD = 5'd3, SUB = 5'd4;
    localparam logic [4:0] AND_ = 5'd5, OR_ = 5'd6, ADDI = 5'd12, BR = 5'd18;
    localparam logic [4:0] JR = 5'd20, JAL = 5'd21, IN_ = 5'd22, OUT_ = 5'd23;
    localparam logic [4:0] HALT_OP = 5'd27;

    logic [22:0] obs;
    assign obs = {OutPort_In, InPort_Out, ramEnable, CONin, PCin, Cout, Zlowout, Zin,
                  Yin, R15in, BAout, Rout, Rin, Grc, Grb, Gra, IRin, MDRout, MDRin,
                  memRead, IncPC, MARin, PCout};

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .memRead(memRead),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .R15in(R15in),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .PCin(PCin),
        .CONin(CONin), .ramEnable(ramEnable),
        .InPort_Out(InPort_Out), .OutPort_In(OutPort_In),
        .alu_op(alu_op), .run(run)
    );

    always #5 clock = ~clock;

    // Total instruction length in cycles, fetch included (halt: up to T3).
    function automatic int exp_len(input logic [4:0] opc);
        case (opc)
            LD, ST:                           return 8;
            BR:                               return 7;
            LDI, ADD, SUB, AND_, OR_, ADDI:   return 6;
            JAL:                              return 5;
            default:                          return 4;
        endcase
    endfunction

    // Strobes expected at step k (0 = T0) of an instruction with opcode opc.
    function automatic logic [22:0] exp_strobes(input logic [4:0] opc, input int k,
                                                input logic con);
        logic [22:0] s;
        s = '0;
        if (k == 0)      begin s[PCOUT] = 1; s[MARIN] = 1; s[INCPC] = 1; end
        else if (k == 1) begin s[MEMREAD] = 1; s[MDRIN] = 1; end
        else if (k == 2) begin s[MDROUT] = 1; s[IRIN] = 1; end
        else begin
            case (opc)
                LD, LDI, ST: case (k)
                    3: begin s[GRB] = 1; s[BAOUT] = 1; s[YIN] = 1; end
                    4: begin s[COUT] = 1; s[ZIN] = 1; end
                    5: if (opc == LDI) begin s[ZLOW] = 1; s[GRA] = 1; s[RIN] = 1; end
                       else begin s[ZLOW] = 1; s[MARIN] = 1; end
                    6: if (opc == LD) begin s[MEMREAD] = 1; s[MDRIN] = 1; end
                       else begin s[GRA] = 1; s[ROUT] = 1; s[MDRIN] = 1; end
                    7: if (opc == LD) begin s[MDROUT] = 1; s[GRA] = 1; s[RIN] = 1; end
                       else s[RAMEN] = 1;
                    default: ;
                endcase
                ADD, SUB, AND_, OR_, ADDI: case (k)
                    3: begin s[GRB] = 1; s[ROUT] = 1; s[YIN] = 1; end
                    4: if (opc == ADDI) begin s[COUT] = 1; s[ZIN] = 1; end
                       else begin s[GRC] = 1; s[ROUT] = 1; s[ZIN] = 1; end
                    5: begin s[ZLOW] = 1; s[GRA] = 1; s[RIN] = 1; end
                    default: ;
                endcase
                BR: case (k)
                    3: begin s[GRA] = 1; s[ROUT] = 1; s[CONIN] = 1; end
                    4: begin s[PCOUT] = 1; s[YIN] = 1; end
                    5: begin s[COUT] = 1; s[ZIN] = 1; end
                    6: if (con) begin s[ZLOW] = 1; s[PCIN] = 1; end
                    default: ;
                endcase
                JR:   if (k == 3) begin s[GRA] = 1; s[ROUT] = 1; s[PCIN] = 1; end
                JAL:  if (k == 3) begin s[R15IN] = 1; s[PCOUT] = 1; end
                      else if (k == 4) begin s[GRA] = 1; s[ROUT] = 1; s[PCIN] = 1; end
                IN_:  if (k == 3) begin s[GRA] = 1; s[RIN] = 1; s[INOUT] = 1; end
                OUT_: if (k == 3) begin s[GRA] = 1; s[ROUT] = 1; s[OUTIN] = 1; end
                default: ;
            endcase
        end
        return s;
    endfunction

    // ALU function: only the register ALU ops in T4 pick something other than add.
    function automatic logic [3:0] exp_alu(input logic [4:0] opc, input int k);
        if (k == 4 && opc >= ADD && opc <= OR_) return 4'(opc - ADD);
        return 4'd0;
    endfunction

    // Runs one instruction from T0. con_mode 0/1 fixes CON, 2 randomizes it.
    // Halt is followed by a quiet stretch and a clear that restarts fetch.
    task automatic run_instr(input logic [31:0] ir, input int con_mode, input string name);
        logic [4:0]  opc;
        logic [22:0] es;
        logic [3:0]  ea;
        int          len;
        opc = ir[31:27];
        len = exp_len(opc);
        IR  = ir;
        for (int k = 0; k < len; k++) begin
            CON = (con_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(con_mode);
            @(negedge clock);
            es = exp_strobes(opc, k, CON);
            ea = exp_alu(opc, k);
            n_cmp++;
            if ({obs, alu_op, run} !== {es, ea, 1'b1}) begin
                n_err++;
                $display("FAIL %s ir=%h T%0d: got strobes=%h alu_op=%0d run=%b, want strobes=%h alu_op=%0d run=1",
                         name, ir, k, obs, alu_op, run, es, ea);
            end
            @(posedge clock); #1;
        end
        if (opc == HALT_OP) begin
            for (int c = 0; c < 12; c++) begin
                CON = 1'($urandom_range(0, 1));
                @(negedge clock);
                n_cmp++;
                if ({obs, alu_op, run} !== 28'd0) begin
                    n_err++;
                    $display("FAIL %s halt cycle %0d: got strobes=%h alu_op=%0d run=%b, want all 0",
                             name, c, obs, alu_op, run);
                end
                @(posedge clock); #1;
            end
            clear = 1'b1;
            @(negedge clock);
            n_cmp++;
            if ({obs, alu_op, run} !== {23'd0, 4'd0, 1'b1}) begin
                n_err++;
                $display("FAIL %s clear in halt: got strobes=%h run=%b, want strobes=0 run=1",
                         name, obs, run);
            end
            @(posedge clock); #1;
            clear = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [22:0] es;
        clear = 1'b1;
        IR    = '0;
        @(posedge clock); #1;
        @(negedge clock);
        n_cmp++;
        if ({obs, alu_op, run} !== {23'd0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_hold: got strobes=%h alu_op=%0d run=%b, want strobes=0 alu_op=0 run=1",
                     obs, alu_op, run);
        end
        @(posedge clock); #1;
        clear = 1'b0;
        IR    = 32'h01000005;
        // Advance an ld to T5, then clear for two cycles.
        repeat (5) begin @(posedge clock); #1; end
        @(negedge clock);
        es = exp_strobes(LD, 5, 1'b0);
        n_cmp++;
        if (obs !== es) begin
            n_err++;
            $display("FAIL reset_ld_t5: got strobes=%h want %h", obs, es);
        end
        @(posedge clock); #1;  // now in T6
        clear = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({obs, alu_op, run} !== {23'd0, 4'd0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_mid_ld cycle %0d: got strobes=%h run=%b, want strobes=0 run=1",
                         c, obs, run);
            end
            @(posedge clock); #1;
        end
        clear = 1'b0;
        @(negedge clock);
        es = exp_strobes(LD, 0, 1'b0);
        n_cmp++;
        if ({obs, alu_op, run} !== {es, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_to_t0: got strobes=%h run=%b, want strobes=%h run=1", obs, run, es);
        end
        // Re-enter T0 cleanly so the next scenario starts at an unchecked T0.
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_jal();
        run_instr(32'hAB000000, 2, "jal");
    endtask

    task automatic test_alu();
        run_instr(32'h18918000, 2, "add");
        run_instr(32'h20918000, 2, "sub");
        run_instr(32'h28918000, 2, "and");
        run_instr(32'h30918000, 2, "or");
        run_instr(32'h61234567, 2, "addi");
        run_instr(32'h08000042, 2, "ldi");
    endtask

    task automatic test_ld_st();
        run_instr(32'h01000005, 2, "ld");
        run_instr(32'h11000005, 2, "st");
    endtask

    task automatic test_br();
        run_instr(32'h90000000, 0, "br_con0");
        run_instr(32'h90000000, 1, "br_con1");
    endtask

    task automatic test_short_ops();
        run_instr(32'hA0800000, 2, "jr");
        run_instr(32'hB0800000, 2, "in");
        run_instr(32'hB8800000, 2, "out");
        run_instr(32'hD0000000, 2, "nop");
    endtask

    task automatic test_halt_undefined();
        run_instr(32'hD8000000, 2, "halt");
        run_instr(32'hF8000000, 2, "undef");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [4:0]  opc;
        for (int i = 0; i < 60; i++) begin
            opc = 5'($urandom_range(0, 31));
            r   = $urandom();
            run_instr({opc, r[26:0]}, 2, "random");
        end
        // Final return to T0 after the last random instruction.
        @(negedge clock);
        n_cmp++;
        if (obs !== exp_strobes(LD, 0, 1'b0) || run !== 1'b1) begin
            n_err++;
            $display("FAIL final_t0: got strobes=%h run=%b, want fetch T0 strobes run=1", obs, run);
        end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_alu();
        test_ld_st();
        test_br();
        test_short_ops();
        test_halt_undefined();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog: the sequence above is bounded, this only guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
